// File: rtl/cmd_sequencer_if.sv
// Signal bundle between cmd_sequencer, its host/debug loader and the RemoteComm responder.
// master = host + RemoteComm side, slave = the sequencer.
interface cmd_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // host / loader side
    logic             ld_en;
    logic [IDX_W-1:0] ld_addr;
    logic [15:0]      ld_data;
    logic [IDX_W:0]   num_cmds;
    logic             stop_on_err;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [IDX_W:0]   fail_cnt;
    logic [IDX_W-1:0] err_idx;
    logic [1:0]       err_code;

    // RemoteComm side
    logic [15:0]      cmd;
    logic             snd_cmd;
    logic             cmd_snt;
    logic             resp_rdy;
    logic [7:0]       resp;

    modport master (
        output ld_en, ld_addr, ld_data, num_cmds, stop_on_err, start,
        output cmd_snt, resp_rdy, resp,
        input  busy, done, pass, fail_cnt, err_idx, err_code,
        input  cmd, snd_cmd
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, num_cmds, stop_on_err, start,
        input  cmd_snt, resp_rdy, resp,
        output busy, done, pass, fail_cnt, err_idx, err_code,
        output cmd, snd_cmd
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Command-script player: issues a loaded list of 16-bit commands to RemoteComm,
// checks each response byte against POS_ACK with a per-command timeout.
module cmd_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TMO_CYC = 1000000,
    parameter int unsigned TMO_W   = 24,
    parameter logic [7:0]  POS_ACK = 8'hA5
) (
    input logic            clk,
    input logic            rst_n,
    cmd_sequencer_if.slave sif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_NAK  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitSnt,
        StWaitResp,
        StNext,
        StFin
    } state_e;

    state_e           r_state, w_state_d;
    logic [15:0]      r_mem [DEPTH];
    logic [15:0]      r_cmd;
    logic [IDX_W-1:0] r_idx, w_idx_d;
    logic [CNT_W-1:0] r_num, w_num_d;
    logic             r_stop, w_stop_d;
    logic [TMO_W-1:0] r_tmo, w_tmo_d;
    logic [1:0]       r_cur_code, w_cur_code_d;
    logic [CNT_W-1:0] r_fail_cnt, w_fail_cnt_d;
    logic [IDX_W-1:0] r_err_idx, w_err_idx_d;
    logic [1:0]       r_err_code, w_err_code_d;
    logic             r_pass, w_pass_d;

    logic w_wr_en;
    logic w_tmo_hit;
    logic w_fail;
    logic w_last;

    assign w_wr_en   = sif.ld_en && (r_state == StIdle);
    assign w_tmo_hit = (r_tmo == TMO_LAST);
    assign w_fail    = (r_cur_code != ERR_NONE);
    assign w_last    = ({1'b0, r_idx} == (r_num - 1'b1));

    always_comb begin
        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_num_d      = r_num;
        w_stop_d     = r_stop;
        w_tmo_d      = r_tmo;
        w_cur_code_d = r_cur_code;
        w_fail_cnt_d = r_fail_cnt;
        w_err_idx_d  = r_err_idx;
        w_err_code_d = r_err_code;
        w_pass_d     = r_pass;

        unique case (r_state)
            StIdle: begin
                if (sif.start) begin
                    w_num_d      = (sif.num_cmds > DEPTH_C) ? DEPTH_C : sif.num_cmds;
                    w_stop_d     = sif.stop_on_err;
                    w_idx_d      = '0;
                    w_fail_cnt_d = '0;
                    w_err_idx_d  = '0;
                    w_err_code_d = ERR_NONE;
                    if (sif.num_cmds == '0) begin
                        w_pass_d  = 1'b1;
                        w_state_d = StFin;
                    end else begin
                        w_pass_d  = 1'b0;
                        w_state_d = StSend;
                    end
                end
            end

            StSend: begin
                w_tmo_d      = '0;
                w_cur_code_d = ERR_NONE;
                w_state_d    = StWaitSnt;
            end

            // A response may overtake cmd_snt; it also beats a same-cycle timeout.
            StWaitSnt, StWaitResp: begin
                w_tmo_d = r_tmo + 1'b1;
                if (sif.resp_rdy) begin
                    w_cur_code_d = (sif.resp == POS_ACK) ? ERR_NONE : ERR_NAK;
                    w_state_d    = StNext;
                end else if (w_tmo_hit) begin
                    w_cur_code_d = ERR_TMO;
                    w_state_d    = StNext;
                end else if ((r_state == StWaitSnt) && sif.cmd_snt) begin
                    w_state_d = StWaitResp;
                end
            end

            StNext: begin
                if (w_fail) begin
                    if (r_fail_cnt != CNT_MAX) begin
                        w_fail_cnt_d = r_fail_cnt + 1'b1;
                    end
                    if (r_fail_cnt == '0) begin
                        w_err_idx_d  = r_idx;
                        w_err_code_d = r_cur_code;
                    end
                end
                if ((w_fail && r_stop) || w_last) begin
                    w_pass_d  = !w_fail && (r_fail_cnt == '0);
                    w_state_d = StFin;
                end else begin
                    w_idx_d   = r_idx + 1'b1;
                    w_state_d = StSend;
                end
            end

            StFin: begin
                w_state_d = StIdle;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cmd      <= '0;
            r_idx      <= '0;
            r_num      <= '0;
            r_stop     <= 1'b0;
            r_tmo      <= '0;
            r_cur_code <= ERR_NONE;
            r_fail_cnt <= '0;
            r_err_idx  <= '0;
            r_err_code <= ERR_NONE;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_idx      <= w_idx_d;
            r_num      <= w_num_d;
            r_stop     <= w_stop_d;
            r_tmo      <= w_tmo_d;
            r_cur_code <= w_cur_code_d;
            r_fail_cnt <= w_fail_cnt_d;
            r_err_idx  <= w_err_idx_d;
            r_err_code <= w_err_code_d;
            r_pass     <= w_pass_d;
            if (r_state == StSend) begin
                r_cmd <= r_mem[r_idx];
            end
        end
    end

    // Script memory survives reset so a run can be replayed after an abort.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[sif.ld_addr] <= sif.ld_data;
        end
    end

    assign sif.cmd      = (r_state == StSend) ? r_mem[r_idx] : r_cmd;
    assign sif.snd_cmd  = (r_state == StSend);
    assign sif.busy     = (r_state != StIdle);
    assign sif.done     = (r_state == StFin);
    assign sif.pass     = r_pass;
    assign sif.fail_cnt = r_fail_cnt;
    assign sif.err_idx  = r_err_idx;
    assign sif.err_code = r_err_code;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: scripted RemoteComm responder, send/done monitor and an
// expected-command queue compared against the observed sends of each run.
module tb_cmd_sequencer;
    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMO   = 100;

    localparam int MNorm   = 0;  // cmd_snt at +2, response at +4
    localparam int MSilent = 1;  // no reaction
    localparam int M99     = 2;  // response 99 cycles after snd_cmd
    localparam int MEarly  = 3;  // response at +2, no cmd_snt
    localparam int MHang   = 4;  // cmd_snt only
    localparam int MTie    = 5;  // response on the timeout cycle

    typedef logic [IDX_W:0]   cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmd_sequencer_if #(.DEPTH(DEPTH)) sif ();

    cmd_sequencer #(
        .DEPTH  (DEPTH),
        .TMO_CYC(TMO),
        .TMO_W  (24),
        .POS_ACK(8'hA5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sif  (sif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_q [$];
    int          rsp_mode [32];
    logic [7:0]  rsp_byte [32];
    int          run_id = 0;

    // Monitor-owned observation records
    logic [15:0] obs_cmd [512];
    int          obs_cyc [512];
    int          n_obs = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_pass, done_busy;
    cnt_t        done_fcnt;
    idx_t        done_eidx;
    logic [1:0]  done_ecode;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sif.snd_cmd && n_obs < 512) begin
            obs_cmd[n_obs] = sif.cmd;
            obs_cyc[n_obs] = cyc;
            n_obs = n_obs + 1;
        end
        if (sif.done) begin
            done_cyc   = cyc;
            done_pass  = sif.pass;
            done_busy  = sif.busy;
            done_fcnt  = sif.fail_cnt;
            done_eidx  = sif.err_idx;
            done_ecode = sif.err_code;
            done_cnt   = done_cnt + 1;
        end
    end

    // RemoteComm responder; timing counted in cycles after the snd_cmd cycle
    initial begin
        int rk, last_run, m;
        logic [7:0] b;
        sif.cmd_snt  = 1'b0;
        sif.resp_rdy = 1'b0;
        sif.resp     = '0;
        rk = 0;
        last_run = -1;
        forever begin
            @(negedge clk);
            if (sif.snd_cmd) begin
                if (run_id != last_run) begin
                    rk = 0;
                    last_run = run_id;
                end
                m = rsp_mode[rk % 32];
                b = rsp_byte[rk % 32];
                rk++;
                if (m == MEarly) begin
                    repeat (2) @(negedge clk);
                    sif.resp = b; sif.resp_rdy = 1'b1;
                    @(negedge clk);
                    sif.resp_rdy = 1'b0;
                end else if (m != MSilent) begin
                    repeat (2) @(negedge clk);
                    sif.cmd_snt = 1'b1;
                    @(negedge clk);
                    sif.cmd_snt = 1'b0;
                    if (m != MHang) begin
                        if (m == MNorm) @(negedge clk);
                        else if (m == M99) repeat (96) @(negedge clk);
                        else repeat (97) @(negedge clk);
                        sif.resp = b; sif.resp_rdy = 1'b1;
                        @(negedge clk);
                        sif.resp_rdy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic kick(input int n, input bit stop, output int t);
        @(negedge clk);
        run_id++;
        sif.num_cmds    = cnt_t'(n);
        sif.stop_on_err = stop;
        sif.start       = 1'b1;
        t = cyc;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic wait_done(input int dbase, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (done_cnt > dbase) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({sif.cmd, sif.snd_cmd, sif.busy, sif.done, sif.pass, sif.fail_cnt, sif.err_idx,
             sif.err_code} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got cmd=%h snd=%b busy=%b done=%b pass=%b fc=%0d ei=%0d ec=%b want all 0",
                     sif.cmd, sif.snd_cmd, sif.busy, sif.done, sif.pass, sif.fail_cnt,
                     sif.err_idx, sif.err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({sif.busy, sif.snd_cmd, sif.done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset got busy/snd/done=%b want 000",
                     {sif.busy, sif.snd_cmd, sif.done});
        end
    endtask

    task automatic test_load_pass();
        int t, base, dbase, k;
        bit ok;
        logic [15:0] e;
        @(negedge clk);
        sif.ld_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = (i == 0) ? 16'h2000 : (i == 1) ? 16'h4001 :
                           (i == 2) ? 16'h5BF1 : 16'h1000 + 16'(i);
            sif.ld_addr = idx_t'(i);
            sif.ld_data = model_mem[i];
            @(negedge clk);
        end
        sif.ld_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rsp_mode[i] = MNorm;
            rsp_byte[i] = 8'hA5;
            exp_q.push_back(model_mem[i]);
        end
        base = n_obs; dbase = done_cnt;
        kick(3, 1'b0, t);
        wait_done(dbase, ok);
        total++;
        if (ok !== 1'b1 || n_obs - base !== 3) begin
            bad++; $display("FAIL pass_sends got done=%0b sends=%0d want 1 3", ok, n_obs - base);
        end
        k = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_cmd[k] !== e) begin
                bad++; $display("FAIL pass_cmd%0d got=%h want=%h", k - base, obs_cmd[k], e);
            end
            k++;
        end
        total++;
        if (obs_cyc[base] !== t + 1 || obs_cyc[base + 1] - obs_cyc[base] !== 6 ||
            done_cyc !== obs_cyc[base + 2] + 6) begin
            bad++;
            $display("FAIL pass_timing got snd0=%0d gap=%0d done=%0d want %0d 6 %0d",
                     obs_cyc[base], obs_cyc[base + 1] - obs_cyc[base], done_cyc, t + 1,
                     obs_cyc[base + 2] + 6);
        end
        total++;
        if ({done_busy, done_pass, done_fcnt, done_ecode} !== {1'b1, 1'b1, cnt_t'(0), 2'b00}) begin
            bad++;
            $display("FAIL pass_status got busy=%b pass=%b fc=%0d ec=%b want 1 1 0 00",
                     done_busy, done_pass, done_fcnt, done_ecode);
        end
        total++;
        if ({sif.busy, sif.done, sif.pass} !== 3'b001) begin
            bad++; $display("FAIL pass_after got busy/done/pass=%b want 001",
                            {sif.busy, sif.done, sif.pass});
        end
    endtask

    task automatic test_nak();
        int t, base, dbase, k, want_n;
        bit ok;
        logic [15:0] e;
        for (int r = 0; r < 2; r++) begin
            want_n = (r == 0) ? 2 : 3;
            for (int i = 0; i < 3; i++) begin
                rsp_mode[i] = MNorm;
                rsp_byte[i] = (i == 1) ? 8'h5A : 8'hA5;
            end
            for (int i = 0; i < want_n; i++) exp_q.push_back(model_mem[i]);
            base = n_obs; dbase = done_cnt;
            kick(3, (r == 0), t);
            wait_done(dbase, ok);
            total++;
            if (ok !== 1'b1 || n_obs - base !== want_n) begin
                bad++; $display("FAIL nak%0d_sends got done=%0b sends=%0d want 1 %0d",
                                r, ok, n_obs - base, want_n);
            end
            k = base;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_cmd[k] !== e) begin
                    bad++; $display("FAIL nak%0d_cmd%0d got=%h want=%h", r, k - base, obs_cmd[k], e);
                end
                k++;
            end
            total++;
            if ({done_pass, done_fcnt, done_eidx, done_ecode} !==
                {1'b0, cnt_t'(1), idx_t'(1), 2'b01}) begin
                bad++;
                $display("FAIL nak%0d_status got pass=%b fc=%0d ei=%0d ec=%b want 0 1 1 01",
                         r, done_pass, done_fcnt, done_eidx, done_ecode);
            end
        end
    endtask

    task automatic test_zero();
        int t, base, dbase;
        bit ok;
        base = n_obs; dbase = done_cnt;
        kick(0, 1'b0, t);
        wait_done(dbase, ok);
        total++;
        if (ok !== 1'b1 || done_cyc !== t + 1 || n_obs - base !== 0) begin
            bad++; $display("FAIL zero_done got done=%0b cyc=%0d sends=%0d want 1 %0d 0",
                            ok, done_cyc, n_obs - base, t + 1);
        end
        total++;
        if ({done_busy, done_pass, done_fcnt, done_ecode} !== {1'b1, 1'b1, cnt_t'(0), 2'b00}) begin
            bad++; $display("FAIL zero_status got busy=%b pass=%b fc=%0d ec=%b want 1 1 0 00",
                            done_busy, done_pass, done_fcnt, done_ecode);
        end
    endtask

    task automatic test_timeout();
        int t, base, dbase;
        bit ok;
        rsp_mode[0] = MSilent; rsp_mode[1] = MNorm; rsp_byte[1] = 8'hA5;
        base = n_obs; dbase = done_cnt;
        kick(2, 1'b0, t);
        wait_done(dbase, ok);
        total++;
        if (ok !== 1'b1 || n_obs - base !== 2 || obs_cyc[base + 1] - obs_cyc[base] !== TMO + 2) begin
            bad++; $display("FAIL tmo_gap got done=%0b sends=%0d gap=%0d want 1 2 %0d",
                            ok, n_obs - base, obs_cyc[base + 1] - obs_cyc[base], TMO + 2);
        end
        total++;
        if ({done_pass, done_fcnt, done_eidx, done_ecode} !== {1'b0, cnt_t'(1), idx_t'(0), 2'b10}) begin
            bad++; $display("FAIL tmo_status got pass=%b fc=%0d ei=%0d ec=%b want 0 1 0 10",
                            done_pass, done_fcnt, done_eidx, done_ecode);
        end
        // response one cycle before expiry, then on the expiry cycle itself
        for (int r = 0; r < 2; r++) begin
            rsp_mode[0] = (r == 0) ? M99 : MTie; rsp_byte[0] = 8'hA5;
            base = n_obs; dbase = done_cnt;
            kick(1, 1'b1, t);
            wait_done(dbase, ok);
            total++;
            if (ok !== 1'b1 || done_cyc - obs_cyc[base] !== TMO + 1 + r ||
                {done_pass, done_fcnt, done_ecode} !== {1'b1, cnt_t'(0), 2'b00}) begin
                bad++;
                $display("FAIL tmo_late%0d got done=%0b dly=%0d pass=%b fc=%0d ec=%b want 1 %0d 1 0 00",
                         r, ok, done_cyc - obs_cyc[base], done_pass, done_fcnt, done_ecode,
                         TMO + 1 + r);
            end
        end
    endtask

    task automatic test_clamp();
        int t, base, dbase, k;
        bit ok;
        logic [15:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            rsp_mode[i] = MNorm;
            rsp_byte[i] = 8'hA5;
            exp_q.push_back(model_mem[i]);
        end
        base = n_obs; dbase = done_cnt;
        kick(DEPTH + 5, 1'b1, t);
        wait_done(dbase, ok);
        total++;
        if (ok !== 1'b1 || n_obs - base !== DEPTH) begin
            bad++; $display("FAIL clamp_sends got done=%0b sends=%0d want 1 %0d",
                            ok, n_obs - base, DEPTH);
        end
        k = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_cmd[k] !== e) begin
                bad++; $display("FAIL clamp_cmd%0d got=%h want=%h", k - base, obs_cmd[k], e);
            end
            k++;
        end
        total++;
        if ({done_pass, done_fcnt} !== {1'b1, cnt_t'(0)}) begin
            bad++; $display("FAIL clamp_status got pass=%b fc=%0d want 1 0", done_pass, done_fcnt);
        end
    endtask

    task automatic test_busy_ignore();
        int t, base, dbase;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            rsp_mode[i] = MNorm;
            rsp_byte[i] = 8'hA5;
        end
        base = n_obs; dbase = done_cnt;
        kick(2, 1'b0, t);
        repeat (2) @(negedge clk);
        sif.ld_en = 1'b1; sif.ld_addr = '0; sif.ld_data = 16'hDEAD;
        sif.num_cmds = cnt_t'(5); sif.start = 1'b1;
        @(negedge clk);
        sif.ld_en = 1'b0; sif.start = 1'b0;
        wait_done(dbase, ok);
        repeat (10) @(negedge clk);
        total++;
        if (ok !== 1'b1 || n_obs - base !== 2 || done_cnt !== dbase + 1 || sif.busy !== 1'b0) begin
            bad++; $display("FAIL busy_restart got sends=%0d dones=%0d busy=%b want 2 1 0",
                            n_obs - base, done_cnt - dbase, sif.busy);
        end
        exp_q.push_back(model_mem[0]);
        base = n_obs; dbase = done_cnt;
        kick(1, 1'b0, t);
        wait_done(dbase, ok);
        total++;
        if (obs_cmd[base] !== exp_q.pop_front()) begin
            bad++; $display("FAIL busy_mem got=%h want=%h", obs_cmd[base], model_mem[0]);
        end
    endtask

    task automatic test_early_resp();
        int t, base, dbase;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            rsp_mode[i] = MEarly;
            rsp_byte[i] = (i == 1) ? 8'h00 : 8'hA5;
        end
        base = n_obs; dbase = done_cnt;
        kick(3, 1'b0, t);
        wait_done(dbase, ok);
        total++;
        if (ok !== 1'b1 || n_obs - base !== 3 || obs_cyc[base + 1] - obs_cyc[base] !== 4) begin
            bad++; $display("FAIL early_sends got done=%0b sends=%0d gap=%0d want 1 3 4",
                            ok, n_obs - base, obs_cyc[base + 1] - obs_cyc[base]);
        end
        total++;
        if ({done_pass, done_fcnt, done_eidx, done_ecode} !== {1'b0, cnt_t'(1), idx_t'(1), 2'b01}) begin
            bad++; $display("FAIL early_status got pass=%b fc=%0d ei=%0d ec=%b want 0 1 1 01",
                            done_pass, done_fcnt, done_eidx, done_ecode);
        end
    endtask

    task automatic test_reset_mid();
        int t, base, dbase, k;
        bit ok;
        logic [15:0] e;
        for (int i = 0; i < 3; i++) rsp_mode[i] = MHang;
        base = n_obs; dbase = done_cnt;
        kick(3, 1'b0, t);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({sif.cmd, sif.snd_cmd, sif.busy, sif.done, sif.pass, sif.fail_cnt, sif.err_idx,
             sif.err_code} !== '0 || n_obs - base !== 1) begin
            bad++; $display("FAIL rstmid_outputs got cmd=%h busy=%b fc=%0d sends=%0d want 0 0 0 1",
                            sif.cmd, sif.busy, sif.fail_cnt, n_obs - base);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (done_cnt !== dbase || sif.busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_nodone got dones=%0d busy=%b want 0 0",
                            done_cnt - dbase, sif.busy);
        end
        for (int i = 0; i < 3; i++) begin
            rsp_mode[i] = MNorm;
            rsp_byte[i] = 8'hA5;
            exp_q.push_back(model_mem[i]);
        end
        base = n_obs; dbase = done_cnt;
        kick(3, 1'b1, t);
        wait_done(dbase, ok);
        total++;
        if (ok !== 1'b1 || n_obs - base !== 3 || done_pass !== 1'b1) begin
            bad++; $display("FAIL replay_run got done=%0b sends=%0d pass=%b want 1 3 1",
                            ok, n_obs - base, done_pass);
        end
        k = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_cmd[k] !== e) begin
                bad++; $display("FAIL replay_cmd%0d got=%h want=%h", k - base, obs_cmd[k], e);
            end
            k++;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        sif.ld_en       = 1'b0;
        sif.ld_addr     = '0;
        sif.ld_data     = '0;
        sif.num_cmds    = '0;
        sif.stop_on_err = 1'b0;
        sif.start       = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_load_pass();
        test_nak();
        test_zero();
        test_timeout();
        test_clamp();
        test_busy_ignore();
        test_early_resp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
